// File: rtl/ifft64_bitrev_reorder_if.sv
// Sample stream bus for the IFFT output reorder buffer: bit-reversed frame in, natural-order frame out.
// The slave modport is the reorder block's view; the master modport is the producer/consumer side.
interface ifft64_bitrev_reorder_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_sop;
  logic                  out_eop;

  modport slave (
    input  in_valid, in_data,
    output out_valid, out_data, out_sop, out_eop
  );

  modport master (
    output in_valid, in_data,
    input  out_valid, out_data, out_sop, out_eop
  );
endinterface

// File: rtl/ifft64_bitrev_reorder.sv
// Ping-pong reorder buffer: writes each frame at bit-reversed addresses,
// then reads it back linearly so the frame leaves in natural index order.
module ifft64_bitrev_reorder #(
  parameter int DATA_WIDTH = 16,
  parameter int LOG2_N     = 6
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clken_i,
  ifft64_bitrev_reorder_if.slave bus
);
  localparam int N = 1 << LOG2_N;
  localparam logic [LOG2_N-1:0] LastIdx = '1;

  typedef enum logic {IDLE, READ} state_t;

  logic [DATA_WIDTH-1:0] mem [2][N];

  state_t                state_q, state_d;
  logic [LOG2_N-1:0]     wrCnt_q, wrCnt_d;
  logic [LOG2_N-1:0]     rdAddr_q, rdAddr_d;
  logic                  wrBank_q, wrBank_d;
  logic                  rdBank_q, rdBank_d;
  logic [1:0]            full_q, full_d;
  logic                  outValid_q, outValid_d;
  logic                  outSop_q, outSop_d;
  logic                  outEop_q, outEop_d;
  logic [DATA_WIDTH-1:0] outData_q, outData_d;

  logic                  wrDone;
  logic [1:0]            fullSet;
  logic [1:0]            fullClr;

  function automatic logic [LOG2_N-1:0] bitrev(input logic [LOG2_N-1:0] a);
    logic [LOG2_N-1:0] r;
    r = '0;
    for (int i = 0; i < LOG2_N; i++) r[i] = a[LOG2_N-1-i];
    return r;
  endfunction

  // Storage is deliberately left unreset; stale contents are never read before being rewritten.
  always_ff @(posedge clk_i) begin
    if (rst_ni && clken_i && bus.in_valid) mem[wrBank_q][bitrev(wrCnt_q)] <= bus.in_data;
  end

  always_comb begin
    state_d    = state_q;
    wrCnt_d    = wrCnt_q;
    rdAddr_d   = rdAddr_q;
    wrBank_d   = wrBank_q;
    rdBank_d   = rdBank_q;
    outValid_d = outValid_q;
    outSop_d   = outSop_q;
    outEop_d   = outEop_q;
    outData_d  = outData_q;
    fullSet    = 2'b00;
    fullClr    = 2'b00;

    wrDone = bus.in_valid && (wrCnt_q == LastIdx);
    if (bus.in_valid) wrCnt_d = wrCnt_q + 1'b1;
    if (wrDone) begin
      fullSet  = wrBank_q ? 2'b10 : 2'b01;
      wrBank_d = ~wrBank_q;
    end

    case (state_q)
      IDLE: begin
        outValid_d = 1'b0;
        outSop_d   = 1'b0;
        outEop_d   = 1'b0;
        if (full_q[rdBank_q]) begin
          state_d  = READ;
          rdAddr_d = '0;
        end
      end
      READ: begin
        outValid_d = 1'b1;
        outData_d  = mem[rdBank_q][rdAddr_q];
        outSop_d   = (rdAddr_q == '0);
        outEop_d   = (rdAddr_q == LastIdx);
        rdAddr_d   = rdAddr_q + 1'b1;
        if (rdAddr_q == LastIdx) begin
          fullClr  = rdBank_q ? 2'b10 : 2'b01;
          rdBank_d = ~rdBank_q;
          // A frame completing on this same edge still counts, keeping readout gapless.
          if (!(full_q[~rdBank_q] || fullSet[~rdBank_q])) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    full_d = (full_q | fullSet) & ~fullClr;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      wrCnt_q    <= '0;
      rdAddr_q   <= '0;
      wrBank_q   <= 1'b0;
      rdBank_q   <= 1'b0;
      full_q     <= 2'b00;
      outValid_q <= 1'b0;
      outSop_q   <= 1'b0;
      outEop_q   <= 1'b0;
      outData_q  <= '0;
    end else if (clken_i) begin
      state_q    <= state_d;
      wrCnt_q    <= wrCnt_d;
      rdAddr_q   <= rdAddr_d;
      wrBank_q   <= wrBank_d;
      rdBank_q   <= rdBank_d;
      full_q     <= full_d;
      outValid_q <= outValid_d;
      outSop_q   <= outSop_d;
      outEop_q   <= outEop_d;
      outData_q  <= outData_d;
    end
  end

  assign bus.out_valid = outValid_q;
  assign bus.out_data  = outData_q;
  assign bus.out_sop   = outSop_q;
  assign bus.out_eop   = outEop_q;
endmodule

// File: tb/tb_ifft64_bitrev_reorder.sv
// Scoreboard bench for the bit-reverse reorder buffer: ramp, back-to-back, gappy clken,
// resets mid-input and mid-readout, plus an 8-point instance.
module tb_ifft64_bitrev_reorder;
  localparam int DW = 16;
  localparam int N  = 64;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clken = 1'b1;

  always #5 clk = ~clk;

  ifft64_bitrev_reorder_if #(.DATA_WIDTH(DW)) io ();
  ifft64_bitrev_reorder_if #(.DATA_WIDTH(DW)) io3 ();

  ifft64_bitrev_reorder #(.DATA_WIDTH(DW), .LOG2_N(6)) dut (
    .clk_i(clk), .rst_ni(rst_n), .clken_i(clken), .bus(io)
  );

  ifft64_bitrev_reorder #(.DATA_WIDTH(DW), .LOG2_N(3)) dut3 (
    .clk_i(clk), .rst_ni(rst_n), .clken_i(clken), .bus(io3)
  );

  int checks = 0;
  int failures = 0;
  exp_t sbq[$];
  logic [DW-1:0] q3[$];
  logic [DW-1:0] frameBuf [N];
  int framePos = 0;
  int cyc = 0;
  int lastInEdge = 0;
  bit latencyArm = 0;
  int run = 0;
  int maxRun = 0;
  int outIdx = 0;
  int lastOutIdx = -1;
  logic [DW+2:0] prevOut = '0;

  function automatic int bitrev6(input int a);
    int r;
    r = 0;
    for (int i = 0; i < 6; i++) if (a[i]) r = r | (1 << (5 - i));
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expd);
    checks++;
    assert (obs === expd) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expd);
    end
  endtask

  // Model: collect a frame in arrival order, then queue it in natural order on the last sample.
  task automatic recordSample(input logic [DW-1:0] d);
    frameBuf[framePos] = d;
    if (framePos == N - 1) begin
      lastInEdge = cyc + 1;
      for (int m = 0; m < N; m++) sbq.push_back('{frameBuf[bitrev6(m)], m == 0, m == N - 1});
      framePos = 0;
    end else begin
      framePos++;
    end
  endtask

  task automatic applyStimulus(input bit v, input logic [DW-1:0] d, input bit ce);
    @(negedge clk);
    io.in_valid = v;
    io.in_data  = d;
    clken       = ce;
    if (v && ce && rst_n) recordSample(d);
  endtask

  task automatic drain(input string tag, input bit randCe);
    int k;
    k = 0;
    while (sbq.size() > 0 && k < 1000) begin
      applyStimulus(1'b0, '0, randCe ? 1'($urandom_range(0, 1)) : 1'b1);
      k++;
    end
    repeat (4) applyStimulus(1'b0, '0, 1'b1);
    checkOutput(tag, sbq.size(), 0);
  endtask

  // Called at a negedge; the reset edge that follows has clken low to show reset overrides it.
  task automatic doReset();
    rst_n       = 1'b0;
    io.in_valid = 1'b0;
    clken       = 1'b0;
    sbq.delete();
    framePos    = 0;
    @(negedge clk);
    clken = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  always @(posedge clk) begin
    logic ceE, rstE;
    exp_t e;
    cyc++;
    ceE  = clken;
    rstE = rst_n;
    #1;
    if (!rstE) begin
      checkOutput("reset_outputs", {io.out_valid, io.out_sop, io.out_eop, io.out_data}, '0);
      run = 0;
      lastOutIdx = -1;
    end else if (!ceE) begin
      checkOutput("clken_hold", {io.out_valid, io.out_sop, io.out_eop, io.out_data}, prevOut);
    end else if (io.out_valid) begin
      run++;
      if (run > maxRun) maxRun = run;
      outIdx = io.out_sop ? 0 : outIdx + 1;
      lastOutIdx = outIdx;
      checkOutput("sb_level", sbq.size() > 0, 1);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        checkOutput("out_data", io.out_data, e.data);
        checkOutput("sop_eop", {io.out_sop, io.out_eop}, {e.sop, e.eop});
        if (latencyArm && e.sop) begin
          checkOutput("first_latency", cyc - lastInEdge, 2);
          latencyArm = 0;
        end
      end
    end else begin
      run = 0;
    end
    prevOut = {io.out_valid, io.out_sop, io.out_eop, io.out_data};
  end

  always @(posedge clk) begin
    logic ceE, rstE;
    logic [DW-1:0] e3;
    ceE  = clken;
    rstE = rst_n;
    #1;
    if (ceE && rstE && io3.out_valid) begin
      checkOutput("n8_level", q3.size() > 0, 1);
      if (q3.size() > 0) begin
        e3 = q3.pop_front();
        checkOutput("n8_data", io3.out_data, e3);
      end
    end
  end

  initial begin
    logic [DW-1:0] n8exp [8];
    int cnt, k;
    bit v, ce;
    n8exp = '{16'd0, 16'd4, 16'd2, 16'd6, 16'd1, 16'd5, 16'd3, 16'd7};
    io.in_valid  = 1'b0;
    io.in_data   = '0;
    io3.in_valid = 1'b0;
    io3.in_data  = '0;
    rst_n = 1'b0;
    clken = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] ramp frame");
    latencyArm = 1;
    for (int i = 0; i < N; i++) applyStimulus(1'b1, DW'(i), 1'b1);
    drain("drain_ramp", 1'b0);
    checkOutput("latency_seen", latencyArm, 0);

    $display("[TB] back-to-back frames");
    maxRun = 0;
    for (int f = 1; f <= 3; f++)
      for (int i = 0; i < N; i++) applyStimulus(1'b1, DW'(f * 256 + i), 1'b1);
    drain("drain_b2b", 1'b0);
    checkOutput("b2b_run", maxRun, 192);

    $display("[TB] gappy input and clken");
    cnt = 0;
    k = 0;
    while (cnt < N && k < 5000) begin
      v  = 1'($urandom_range(0, 1));
      ce = 1'($urandom_range(0, 1));
      applyStimulus(v, DW'(cnt), ce);
      if (v && ce) cnt++;
      k++;
    end
    drain("drain_gappy", 1'b1);

    $display("[TB] reset mid-input");
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, DW'(16'h500 + i), 1'b1);
    applyStimulus(1'b0, '0, 1'b1);
    doReset();
    for (int i = 0; i < N; i++) applyStimulus(1'b1, DW'(16'h600 + i), 1'b1);
    drain("drain_rst_input", 1'b0);

    $display("[TB] reset mid-readout");
    for (int i = 0; i < N; i++) applyStimulus(1'b1, DW'(16'h700 + i), 1'b1);
    k = 0;
    while (lastOutIdx != 10 && k < 200) begin
      applyStimulus(1'b0, '0, 1'b1);
      k++;
    end
    checkOutput("reach_idx10", lastOutIdx, 10);
    doReset();
    for (int i = 0; i < N; i++) applyStimulus(1'b1, DW'(16'h800 + i), 1'b1);
    drain("drain_rst_readout", 1'b0);

    $display("[TB] 8-point instance");
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      clken        = 1'b1;
      io3.in_valid = 1'b1;
      io3.in_data  = DW'(i);
    end
    for (int m = 0; m < 8; m++) q3.push_back(n8exp[m]);
    @(negedge clk);
    io3.in_valid = 1'b0;
    k = 0;
    while (q3.size() > 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    repeat (4) @(negedge clk);
    checkOutput("drain_n8", q3.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ifft64_bitrev_reorder.md
# ifft64_bitrev_reorder

Output-side reorder buffer for the 64-point IFFT pipeline. It accepts one frame of samples in bit-reversed index order, as the pipelined butterfly stages produce them, and emits the frame in natural order. Storage is a ping-pong pair of N-entry banks, so one frame is written while the previous one is read out. Continuous input streams out gaplessly. The block sits directly after the last butterfly/delay stage, on the same `clk`/`clken` domain.

## Interface
- `DATA_WIDTH`, 16, sample width in bits. Complex data is packed by the caller.
- `LOG2_N`, 6, log2 of frame length (N = 64).
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `clken`  in  1  clock enable. When low, no state or output changes.
- `in_valid`  in  1  `in_data` is a valid sample this cycle.
- `in_data`  in  DATA_WIDTH  input sample, frame order = bit-reversed index.
- `out_valid`  out  1  `out_data` is valid.
- `out_data`  out  DATA_WIDTH  output sample, natural index order.
- `out_sop`  out  1  high with output index 0 of a frame.
- `out_eop`  out  1  high with output index N-1 of a frame.

## Operation
- Every state change requires `clken`=1 at the clock edge.
- **Storage and bank state**
  - Two banks of N×DATA_WIDTH.
  - `full[1:0]` flags, `wr_bank` bit, `rd_bank` bit.
- **Write side**
  - `wr_cnt` is LOG2_N bits. On each accepted sample (`clken`&`in_valid`), write to `bank[wr_bank][bitrev(wr_cnt)]`, then increment `wr_cnt`.
  - When `wr_cnt`=N-1 is accepted: set `full[wr_bank]`, toggle `wr_bank`, wrap `wr_cnt` to 0.
  - Frame boundary comes only from the count. There is no input sop.
- **Read FSM**
  - IDLE: if `full[rd_bank]`, go to READ with `rd_addr`=0.
  - READ: each clken edge, register `bank[rd_bank][rd_addr]` to `out_data` and set `out_valid`=1. Set `out_sop`=(rd_addr==0) and `out_eop`=(rd_addr==N-1). Increment `rd_addr`.
  - At `rd_addr`=N-1: clear `full[rd_bank]` and toggle `rd_bank`.
    - If the other bank is full, or is being set full on this same edge, stay in READ with `rd_addr`=0. This gives back-to-back frames.
    - Otherwise go to IDLE.
  - In IDLE, `out_valid`, `out_sop` and `out_eop` are 0. `out_data` holds its last value.
- **Result:** output index m carries the input sample whose arrival position was bitrev(m).
- **Overflow cannot occur.** The reader drains N samples in N clken cycles, while the writer needs at least N accepted samples to fill the other bank. No overflow flag exists.
- **Simultaneous events**
  - Set of `full[x]` by the writer and clear of `full[y]` by the reader on the same edge are independent.
  - Same-bank set and clear on one edge is impossible by construction.
- **Reset:** a synchronous `rst_n`=0 edge clears counters, `full`, `wr_bank`, `rd_bank` and the FSM (to IDLE), and zeroes all outputs.
  - A partial input frame or a frame mid-readout is discarded.
  - Memory contents are not reset.
  - `rst_n` takes effect regardless of `clken`.

## Timing
- **Reset values:** `out_valid`=0, `out_sop`=0, `out_eop`=0, `out_data`=0.
- **Latency:** last input sample accepted at edge E sets `full` at E. The IDLE→READ transition is taken at E+1. The first output (index 0) is registered at E+2 and visible after E+2. This is two clken edges from the last input.
- With continuous input (`in_valid`=1, `clken`=1), output is continuous after the first frame: `out_eop` of frame k is immediately followed by `out_sop` of frame k+1.
- **clken low:** outputs hold their values, including `out_valid`=1. Downstream must qualify with `clken`.
- Read is synchronous (registered). Writes and reads use different banks, so there is no read-during-write hazard.

## Test plan
- **Ramp frame:** `in_data`=0..63 contiguous. Outputs are 0,32,16,48,8,40,24,56,…,63. `out_sop` with 0, `out_eop` with 63. First output two clken edges after input 63.
- **Back-to-back:** three contiguous frames (ramps offset by 0x100, 0x200, 0x300). Gives 192 contiguous `out_valid` cycles with no gap. sop/eop at indices 0, 63, 64, 127, 128 and 191 of the output stream.
- **Gappy input and clken:** random `in_valid` and `clken` duty of 50%. Output sequence is identical to the ramp test, and nothing changes on `clken`=0 cycles.
- **Reset mid-input:** assert `rst_n`=0 after 20 samples, then send a full ramp frame. Only that one frame is output, correctly ordered, with no stale samples.
- **Reset mid-readout:** assert `rst_n`=0 at output index 10. `out_valid` goes to 0 the next edge. A subsequent frame outputs correctly.
- **LOG2_N=3 build:** input 0..7 gives output 0,4,2,6,1,5,3,7.
